io_pause_controller: RTL and testbench
======================================

// Module: io_pause_controller
// PURPOSE
//  IO-side counterpart of the processor cycle generator's pause handshake. Drives button_pause to
//  freeze the a/b/c/d cycle on an IN/OUT instruction, then releases it by toggling button_state on a
//  debounced key press, capturing the switch word as input data. Sits between board key/switches and the core.
// PARAMETERS
//  DATA_W           8       width of sw_in / io_data
//  DEBOUNCE_CYCLES  250000  consecutive stable clk cycles to accept a key level (5 ms @ 50 MHz)
// PORTS
//  clk           in   1       system clock, all logic on posedge
//  reset         in   1       asynchronous, active-low reset
//  btn_raw       in   1       raw push-button, active-low (0 = pressed), asynchronous to clk
//  sw_in         in   DATA_W  switch word, sampled at accepted press
//  io_req        in   1       current instruction is IN/OUT, valid while phase_b=1
//  phase_b       in   1       cycle generator phase b (clk domain)
//  button_pause  out  1       pause-toggle request to cycle generator
//  button_state  out  1       IO state flag; generator runs while its pause equals this
//  io_data       out  DATA_W  switch word captured at last accepted press
//  io_done       out  1       1-cycle pulse: press accepted, generator released
//  busy          out  1       1 while waiting for operator press (state ARMED)
// BEHAVIOUR
//  Reset (reset=0, immediate): button_state=0, io_data=0, io_done=0, busy=0, button_pause=0,
//   state=IDLE, debounce counter=0, sync flops and clean key level=1 (released), phase_b_d=0.
//  Input conditioning (runs in every state):
//   - btn_raw -> 2-flop synchroniser -> btn_s. Counter CNT_W=$clog2(DEBOUNCE_CYCLES+1) bits.
//   - btn_s != btn_clean: counter increments; reaching DEBOUNCE_CYCLES-1 loads btn_clean=btn_s, counter=0.
//   - btn_s == btn_clean: counter=0. Any bounce restarts the count; no wrap-around possible.
//   - press event = btn_clean 1->0, single cycle. Latency btn_raw fall -> event = 2+DEBOUNCE_CYCLES clks.
//  phase_b rising edge = phase_b & ~phase_b_d (phase_b_d registered copy).
//  FSM (state register, one-hot or binary, reset IDLE):
//   IDLE    : button_pause = io_req (combinational, forced 0 in reset). Must be stable at generator's
//             posedge b. On phase_b rising edge with io_req=1 -> ARMED. Press events ignored (no toggle).
//   ARMED   : button_pause=0, busy=1. Generator has toggled pause and stalls in b.
//             On press event: io_data<=sw_in, button_state<=~button_state, io_done=1 for one cycle -> RELEASE.
//   RELEASE : wait btn_clean=1 (debounced release) -> IDLE. Key held keeps block here; a new io_req
//             arriving meanwhile is not armed until IDLE (generator runs on, io_req re-sampled next b).
//  Simultaneous events: press event in same cycle as IDLE->ARMED arming is discarded; a fresh press is required.
//  button_state toggles exactly once per ARMED episode; never outside ARMED, so pause/state stay matched.
//  io_data holds its value until the next accepted press.
//  Reset mid-operation (any state): all outputs and state return to reset values asynchronously; the
//   cycle generator must be reset in the same system reset so its pause returns to 0 = button_state.
// TESTING (DEBOUNCE_CYCLES=4, DATA_W=8)
//  Reset pulse low 3 clks -> all outputs 0, btn_clean=1, busy=0, io_data=8'h00.
//  io_req=1, phase_b rises at clk t -> button_pause=1 up to t, 0 from t+1; busy=1 from t+1.
//  ARMED, sw_in=8'hA5, btn_raw=0 held 10 clks -> io_done pulses once at 2+4 clks after fall, io_data=8'hA5,
//   button_state 0->1, busy=0; release held 6 clks -> IDLE.
//  ARMED, btn_raw toggles every 2 clks for 20 clks -> no press event, button_state/io_data unchanged, busy=1.
//  IDLE, io_req=0, clean press/release -> button_state, io_data, io_done unchanged.
//  ARMED, reset=0 asynchronously mid-debounce -> outputs to reset values before next clk edge; after
//   release, second IO cycle arms and toggles button_state 0->1 normally.

Source files
------------

// File: rtl/io_pause_if.sv
`default_nettype none
// ============================================================================
// io_pause_if : pause handshake between cycle generator (master) and the
//               IO pause controller (slave).  Rev 1.0
// ============================================================================
interface io_pause_if #(
  parameter int DATA_W = 8
);
  logic              io_req;
  logic              phase_b;
  logic              button_pause;
  logic              button_state;
  logic [DATA_W-1:0] io_data;
  logic              io_done;
  logic              busy;

  modport master (
    output io_req, phase_b,
    input  button_pause, button_state, io_data, io_done, busy
  );

  modport slave (
    input  io_req, phase_b,
    output button_pause, button_state, io_data, io_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/io_pause_controller.sv
`default_nettype none
// ============================================================================
// io_pause_controller : freezes the a/b/c/d cycle on IN/OUT and releases it on
//                       a debounced key press, capturing the switch word.  Rev 1.0
// ============================================================================
module io_pause_controller #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              btn_raw,
  input  wire [DATA_W-1:0] sw_in,
  io_pause_if.slave        bus
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic              btn_clean_q, btn_clean_prev_q;
  logic              phase_b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              button_state_q, button_state_d;
  logic [DATA_W-1:0] io_data_q, io_data_d;

  logic              press;
  logic              phase_b_rise;
  logic              pause_w, busy_w, done_w;

  // Key conditioning; the clean level only moves after an unbroken run of
  // DEBOUNCE_CYCLES samples disagreeing with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q          <= 1'b1;
      sync2_q          <= 1'b1;
      btn_clean_q      <= 1'b1;
      btn_clean_prev_q <= 1'b1;
      cnt_q            <= '0;
      phase_b_q        <= 1'b0;
    end else begin
      sync1_q          <= btn_raw;
      sync2_q          <= sync1_q;
      btn_clean_prev_q <= btn_clean_q;
      phase_b_q        <= bus.phase_b;
      if (sync2_q != btn_clean_q) begin
        if (cnt_q == CNT_LAST) begin
          btn_clean_q <= sync2_q;
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press        = btn_clean_prev_q & ~btn_clean_q;
  assign phase_b_rise = bus.phase_b & ~phase_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      button_state_q <= 1'b0;
      io_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      button_state_q <= button_state_d;
      io_data_q      <= io_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    button_state_d = button_state_q;
    io_data_d      = io_data_q;
    pause_w        = 1'b0;
    busy_w         = 1'b0;
    done_w         = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Presented combinationally so it is settled at the generator's b edge.
        pause_w = bus.io_req & reset;
        if (phase_b_rise && bus.io_req) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        busy_w = 1'b1;
        if (press) begin
          done_w         = 1'b1;
          io_data_d      = sw_in;
          button_state_d = ~button_state_q;
          state_d        = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (btn_clean_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.button_pause = pause_w;
  assign bus.busy         = busy_w;
  assign bus.io_done      = done_w;
  assign bus.button_state = button_state_q;
  assign bus.io_data      = io_data_q;

endmodule
`default_nettype wire

// File: tb/tb_io_pause_controller.sv
`default_nettype none
// ============================================================================
// tb_io_pause_controller : directed scenarios plus randomized traffic checked
//                          against a behavioural model.  Rev 1.0
// ============================================================================
module tb_io_pause_controller;
  localparam int DW = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          btn_raw = 1'b1;
  logic [DW-1:0] sw_in = '0;

  int n_vec = 0;
  int n_err = 0;

  io_pause_if #(.DATA_W(DW)) bus();

  io_pause_controller #(.DATA_W(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_in(sw_in), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw key history, debounced level, and operator-wait flags
  bit          m_armed, m_rel, m_state;
  bit [DW-1:0] m_data;
  bit          m_clean, m_pclean, m_pb;
  bit          rawq[$];
  bit          sh[$];

  task automatic model_reset();
    m_armed = 0; m_rel = 0; m_state = 0; m_data = '0;
    m_clean = 1; m_pclean = 1; m_pb = 0;
    rawq = '{1'b1, 1'b1};
    sh = {};
  endtask

  task automatic model_edge();
    bit press, s, all;
    press = m_pclean && !m_clean;
    if (m_armed && press) begin
      m_data = sw_in; m_state = ~m_state; m_armed = 0; m_rel = 1;
    end else if (m_rel) begin
      if (m_clean) m_rel = 0;
    end else if (!m_armed && bus.io_req && bus.phase_b && !m_pb) begin
      m_armed = 1;
    end
    m_pb = bus.phase_b;
    m_pclean = m_clean;
    s = rawq.pop_front();
    rawq.push_back(btn_raw);
    sh.push_back(s);
    if (sh.size() > DB) sh.delete(0);
    if (sh.size() == DB) begin
      all = 1;
      foreach (sh[i]) if (sh[i] == m_clean) all = 0;
      if (all) m_clean = ~m_clean;
    end
  endtask

  function automatic logic [DW+3:0] model_out();
    return {(!m_armed && !m_rel && bus.io_req && reset), m_state, m_data,
            (m_armed && m_pclean && !m_clean), m_armed};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic arm();
    bus.io_req = 1; bus.phase_b = 0; step();
    bus.phase_b = 1; step();
  endtask

  task automatic test_reset();
    reset = 0; bus.io_req = 1; bus.phase_b = 0; btn_raw = 1;
    model_reset();
    repeat (3) step();
    n_vec++; if (bus.button_pause !== 1'b0) begin n_err++; $display("FAIL rst_pause: got %b exp 0", bus.button_pause); end
    n_vec++; if (bus.button_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b exp 0", bus.button_state); end
    n_vec++; if (bus.io_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h exp 00", bus.io_data); end
    n_vec++; if (bus.io_done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_done_busy: got %b%b exp 00", bus.io_done, bus.busy); end
    reset = 1; bus.io_req = 0;
    step();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_after_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_arm_press();
    bus.io_req = 1; bus.phase_b = 0; step();
    n_vec++; if (bus.button_pause !== 1'b1) begin n_err++; $display("FAIL arm_pause_idle: got %b exp 1", bus.button_pause); end
    bus.phase_b = 1; #1;
    n_vec++; if (bus.button_pause !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL arm_before_edge: got pause %b busy %b exp 1 0", bus.button_pause, bus.busy); end
    step();
    n_vec++; if (bus.button_pause !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL arm_after_edge: got pause %b busy %b exp 0 1", bus.button_pause, bus.busy); end
    sw_in = 8'hA5; btn_raw = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_vec++; if (bus.io_done !== (i == 6)) begin n_err++; $display("FAIL press_done cyc %0d: got %b exp %b", i, bus.io_done, (i == 6)); end
    end
    n_vec++; if (bus.io_data !== 8'hA5 || bus.button_state !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL press_result: got data %h state %b busy %b exp a5 1 0", bus.io_data, bus.button_state, bus.busy);
    end
    btn_raw = 1; bus.phase_b = 0; bus.io_req = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_vec++; if (bus.button_pause !== (i >= 7)) begin n_err++; $display("FAIL release_pause cyc %0d: got %b exp %b", i, bus.button_pause, (i >= 7)); end
    end
    bus.io_req = 0;
  endtask

  task automatic test_bounce();
    arm();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL bounce_arm: got busy %b exp 1", bus.busy); end
    sw_in = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_raw = ~btn_raw;
      step();
      n_vec++; if (bus.io_done !== 1'b0) begin n_err++; $display("FAIL bounce_done cyc %0d: got %b exp 0", i, bus.io_done); end
    end
    n_vec++; if (bus.busy !== 1'b1 || bus.button_state !== 1'b1 || bus.io_data !== 8'hA5) begin
      n_err++; $display("FAIL bounce_hold: got busy %b state %b data %h exp 1 1 a5", bus.busy, bus.button_state, bus.io_data);
    end
    btn_raw = 0; repeat (8) step();
    n_vec++; if (bus.button_state !== 1'b0 || bus.io_data !== 8'h3C) begin
      n_err++; $display("FAIL bounce_exit: got state %b data %h exp 0 3c", bus.button_state, bus.io_data);
    end
    btn_raw = 1; bus.phase_b = 0; bus.io_req = 0; repeat (8) step();
  endtask

  task automatic test_idle_press();
    bus.io_req = 0; sw_in = 8'h77;
    bus.phase_b = 1; step(); bus.phase_b = 0;
    btn_raw = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn_raw = 1;
      step();
      n_vec++; if (bus.io_done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_press cyc %0d: got done %b busy %b exp 0 0", i, bus.io_done, bus.busy); end
    end
    n_vec++; if (bus.button_state !== 1'b0 || bus.io_data !== 8'h3C) begin
      n_err++; $display("FAIL idle_hold: got state %b data %h exp 0 3c", bus.button_state, bus.io_data);
    end
  endtask

  task automatic test_async_reset();
    arm();
    btn_raw = 0; repeat (3) step();
    #1 reset = 0; model_reset();
    #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.io_data !== 8'h00 || bus.button_pause !== 1'b0 || bus.button_state !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got busy %b data %h pause %b state %b exp 0 00 0 0", bus.busy, bus.io_data, bus.button_pause, bus.button_state);
    end
    bus.io_req = 0; bus.phase_b = 0;
    @(negedge clk);
    repeat (2) step();
    reset = 1;
    repeat (8) step();
    btn_raw = 1; repeat (10) step();
    arm();
    sw_in = 8'h5A; btn_raw = 0; repeat (8) step();
    n_vec++; if (bus.button_state !== 1'b1 || bus.io_data !== 8'h5A) begin
      n_err++; $display("FAIL reset_rearm: got state %b data %h exp 1 5a", bus.button_state, bus.io_data);
    end
    btn_raw = 1; bus.phase_b = 0; bus.io_req = 0; repeat (8) step();
  endtask

  task automatic test_random();
    int hold = 0;
    logic [DW+3:0] got;
    logic [DW+3:0] exp;
    for (int c = 0; c < 3000; c++) begin
      if (!reset) reset = 1;
      else if ($urandom_range(0, 599) == 0) reset = 0;
      if ($urandom_range(0, 2) == 0) bus.phase_b = ~bus.phase_b;
      if ($urandom_range(0, 3) == 0) bus.io_req = 1'($urandom_range(0, 1));
      if (hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      sw_in = DW'($urandom);
      step();
      got = {bus.button_pause, bus.button_state, bus.io_data, bus.io_done, bus.busy};
      exp = model_out();
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL random cyc %0d: got %h exp %h", c, got, exp); end
    end
    reset = 1;
  endtask

  initial begin
    bus.io_req = 0; bus.phase_b = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_arm_press();
    test_bounce();
    test_idle_press();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
